// File: rtl/bcd_counter_2digit_pkg.sv
// Shared constants for the two-digit BCD stopwatch and its display multiplexer:
// digit format, run-state encoding and the default timing parameters.
package bcd_counter_2digit_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam int DIV_DEFAULT        = 5_000_000;
    localparam int DEB_CYCLES_DEFAULT = 1_000_000;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } run_state_t;

    // Returns {carry, next digit}; any value at or above 9 rolls to 0 so a
    // digit can never settle on 10..15.
    function automatic logic [BCD_W:0] bcd_inc(input bcd_digit_t d);
        if (d >= BCD_MAX) begin
            return {1'b1, {BCD_W{1'b0}}};
        end
        return {1'b0, d + BCD_W'(1)};
    endfunction

endpackage

// File: rtl/bcd_counter_2digit_if.sv
// Button inputs and display-facing outputs of the BCD stopwatch.
interface bcd_counter_2digit_if import bcd_counter_2digit_pkg::*; ();

    logic       btn_run;
    logic       btn_clr;
    bcd_digit_t data0;
    bcd_digit_t data1;
    logic       running;
    logic       wrap;

    modport master (
        output btn_run, btn_clr,
        input  data0, data1, running, wrap
    );

    modport slave (
        input  btn_run, btn_clr,
        output data0, data1, running, wrap
    );

endinterface

// File: rtl/bcd_counter_2digit_btn_debounce.sv
// Push-button front end: 2-flop synchroniser, stability debouncer and a
// single-cycle press pulse on each accepted low-to-high transition.
module btn_debounce import bcd_counter_2digit_pkg::*; #(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic FPGA_CLK,
    input  logic FPGA_RST,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(DEB_CYCLES);

    logic          sync_a;
    logic          sync_b;
    logic          sync_prev;
    logic [1:0]    fill;
    logic [CW-1:0] run_cnt;
    logic [CW-1:0] run_len;
    logic          armed;

    always_comb begin
        run_len = CW'(1);
        if (sync_b == sync_prev) begin
            run_len = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + CW'(1);
        end
    end

    // The synchroniser still holds reset zeros for two cycles, so those samples
    // are ignored; a button held through reset must first be seen low before
    // a press can be reported (armed).
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            sync_prev <= 1'b0;
            fill      <= 2'b00;
            run_cnt   <= '0;
            level     <= 1'b0;
            press     <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync_a    <= btn_raw;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
            fill      <= {fill[0], 1'b1};
            press     <= 1'b0;
            if (!fill[1]) begin
                run_cnt <= '0;
            end else begin
                run_cnt <= run_len;
                if (run_len == RUN_MAX) begin
                    if (sync_b != level) begin
                        level <= sync_b;
                        press <= sync_b & armed;
                    end
                    if (!sync_b) begin
                        armed <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD stopwatch: run/stop and clear buttons, prescaled count tick,
// 00..99 with a one-cycle wrap pulse.
module bcd_counter_2digit import bcd_counter_2digit_pkg::*; #(
    parameter int DIV        = DIV_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic                  FPGA_CLK,
    input  logic                  FPGA_RST,
    bcd_counter_2digit_if.slave   bus
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    run_state_t     state;
    run_state_t     state_next;
    logic [PW-1:0]  presc;
    logic [PW-1:0]  presc_next;
    bcd_digit_t     d0;
    bcd_digit_t     d1;
    bcd_digit_t     d0_next;
    bcd_digit_t     d1_next;
    logic           wrap_q;
    logic           wrap_next;
    logic [BCD_W:0] inc0;
    logic [BCD_W:0] inc1;
    logic           tick;
    logic           run_ev;
    logic           clr_ev;
    logic           unused_run_level;
    logic           unused_clr_level;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_btn (
        .FPGA_CLK (FPGA_CLK),
        .FPGA_RST (FPGA_RST),
        .btn_raw  (bus.btn_run),
        .level    (unused_run_level),
        .press    (run_ev)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_btn (
        .FPGA_CLK (FPGA_CLK),
        .FPGA_RST (FPGA_RST),
        .btn_raw  (bus.btn_clr),
        .level    (unused_clr_level),
        .press    (clr_ev)
    );

    assign tick = (state == RUN) && (presc == PRESC_LAST);

    // Clear wins over everything; a tick on the same edge as a stop still
    // counts. The prescaler only advances while RUN persists across the edge,
    // so entering RUN starts from zero and pausing throws the partial count away.
    always_comb begin
        state_next = state;
        presc_next = '0;
        d0_next    = d0;
        d1_next    = d1;
        wrap_next  = 1'b0;
        inc0       = bcd_inc(d0);
        inc1       = bcd_inc(d1);
        if (clr_ev) begin
            state_next = STOP;
            d0_next    = '0;
            d1_next    = '0;
        end else begin
            if (run_ev) begin
                state_next = (state == RUN) ? STOP : RUN;
            end
            if (tick) begin
                d0_next = inc0[BCD_W-1:0];
                if (inc0[BCD_W]) begin
                    d1_next   = inc1[BCD_W-1:0];
                    wrap_next = inc1[BCD_W];
                end
            end
            if ((state == RUN) && (state_next == RUN) && !tick) begin
                presc_next = presc + PW'(1);
            end
        end
    end

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            state  <= STOP;
            presc  <= '0;
            d0     <= '0;
            d1     <= '0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_next;
            presc  <= presc_next;
            d0     <= d0_next;
            d1     <= d1_next;
            wrap_q <= wrap_next;
        end
    end

    assign bus.data0   = d0;
    assign bus.data1   = d1;
    assign bus.running = (state == RUN);
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Self-checking bench for bcd_counter_2digit with DIV=4, DEB_CYCLES=3: directed
// scenarios plus random button traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_bcd_counter_2digit;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic FPGA_CLK = 1'b0;
    logic FPGA_RST = 1'b1;

    bcd_counter_2digit_if bus ();

    bcd_counter_2digit #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
        .FPGA_CLK (FPGA_CLK),
        .FPGA_RST (FPGA_RST),
        .bus      (bus)
    );

    always #5 FPGA_CLK = ~FPGA_CLK;

    int errors = 0;
    int checks = 0;
    int range_viol = 0;

    logic [9:0] dut_v;
    logic [9:0] exp_v;
    assign dut_v = {bus.data1, bus.data0, bus.running, bus.wrap};

    always @(negedge FPGA_CLK) begin
        if (bus.data0 > 4'd9 || bus.data1 > 4'd9) range_viol <= range_viol + 1;
    end

    // Reference: count held as an integer 0..99, ticks every DIV cycles of RUN,
    // each button accepted when its last DEB synchronised samples agree.
    always @(posedge FPGA_CLK) begin : ref_model
        int raw [2];
        int pipe [2][2];
        int win [2][DEB];
        int nval [2];
        bit lvl [2];
        bit armed [2];
        bit press_m [2];
        int m_cnt, m_age, s;
        bit m_run, m_wrap, ev_run, ev_clr, tick, same;
        raw[0] = int'(bus.btn_run);
        raw[1] = int'(bus.btn_clr);
        if (FPGA_RST) begin
            for (int b = 0; b < 2; b++) begin
                pipe[b][0] = -1; pipe[b][1] = -1; nval[b] = 0;
                lvl[b] = 0; armed[b] = 0; press_m[b] = 0;
            end
            m_cnt = 0; m_age = 0; m_run = 0; m_wrap = 0;
        end else begin
            ev_run = press_m[0];
            ev_clr = press_m[1];
            tick = m_run && (m_age % DIV == DIV - 1);
            m_wrap = 0;
            if (ev_clr) begin
                m_run = 0; m_cnt = 0; m_age = 0;
            end else begin
                if (tick) begin
                    m_cnt = (m_cnt + 1) % 100;
                    m_wrap = (m_cnt == 0);
                end
                if (ev_run) begin
                    m_run = !m_run; m_age = 0;
                end else if (m_run) begin
                    m_age++;
                end
            end
            for (int b = 0; b < 2; b++) begin
                s = pipe[b][1];
                pipe[b][1] = pipe[b][0];
                pipe[b][0] = raw[b];
                press_m[b] = 0;
                if (s >= 0) begin
                    for (int i = DEB - 1; i > 0; i--) win[b][i] = win[b][i-1];
                    win[b][0] = s;
                    if (nval[b] < DEB) nval[b]++;
                    same = 1;
                    for (int i = 0; i < DEB; i++) if (win[b][i] != s) same = 0;
                    if (nval[b] == DEB && same) begin
                        if (s != int'(lvl[b])) begin
                            press_m[b] = (s == 1) && armed[b];
                            lvl[b] = (s == 1);
                        end
                        if (s == 0) armed[b] = 1;
                    end
                end
            end
        end
        exp_v <= {4'(m_cnt / 10), 4'(m_cnt % 10), m_run, m_wrap};
    end

    task automatic step();
        @(posedge FPGA_CLK);
        #1;
    endtask

    task automatic test_reset();
        FPGA_RST = 1'b1;
        bus.btn_run = 1'b1;
        bus.btn_clr = 1'b0;
        repeat (3) step();
        checks++;
        if (dut_v !== 10'h000) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h want 000", dut_v);
        end
        FPGA_RST = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            checks++;
            if (dut_v !== 10'h000) begin
                errors++;
                $display("[TB] FAIL held_through_reset cycle %0d: got %h want 000", i, dut_v);
                break;
            end
        end
        bus.btn_run = 1'b0;
        repeat (10) step();
        checks++;
        if (dut_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL model_after_reset: got %h want %h", dut_v, exp_v);
        end
    endtask

    task automatic test_debounce();
        int n, m;
        bus.btn_run = 1'b1;
        repeat (2) step();
        bus.btn_run = 1'b0;
        repeat (20) step();
        checks++;
        if (bus.running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_reject: running=%b want 0", bus.running);
        end
        bus.btn_run = 1'b1;
        n = 0;
        while (bus.running !== 1'b1 && n < 20) begin step(); n++; end
        bus.btn_run = 1'b0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("[TB] FAIL run_latency: got %0d cycles want 6", n);
        end
        m = 0;
        while (bus.data0 !== 4'd1 && m < 20) begin step(); m++; end
        checks++;
        if (m != 4) begin
            errors++;
            $display("[TB] FAIL first_tick: got %0d cycles want 4", m);
        end
    endtask

    task automatic test_carry();
        int n;
        n = 0;
        while ({bus.data1, bus.data0} !== 8'h09 && n < 100) begin step(); n++; end
        while ({bus.data1, bus.data0} === 8'h09 && n < 120) begin step(); n++; end
        checks++;
        if (dut_v !== {8'h10, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL carry_09_10: got %h want %h", dut_v, {8'h10, 2'b10});
        end
        n = 0;
        while ({bus.data1, bus.data0} !== 8'h99 && n < 500) begin step(); n++; end
        while ({bus.data1, bus.data0} === 8'h99 && n < 520) begin step(); n++; end
        checks++;
        if (dut_v !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL wrap_99_00: got %h want %h", dut_v, {8'h00, 2'b11});
        end
        step();
        checks++;
        if (bus.wrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_one_cycle: wrap=%b want 0", bus.wrap);
        end
    endtask

    task automatic test_pause();
        int n, m;
        bus.btn_clr = 1'b1;
        repeat (6) step();
        bus.btn_clr = 1'b0;
        repeat (8) step();
        checks++;
        if (dut_v !== 10'h000) begin
            errors++;
            $display("[TB] FAIL clear_state: got %h want 000", dut_v);
        end
        bus.btn_run = 1'b1;
        repeat (6) step();
        bus.btn_run = 1'b0;
        n = 0;
        while ({bus.data1, bus.data0} !== 8'h36 && n < 200) begin step(); n++; end
        bus.btn_run = 1'b1;
        repeat (6) step();
        bus.btn_run = 1'b0;
        checks++;
        if ({bus.data1, bus.data0, bus.running} !== {8'h37, 1'b0}) begin
            errors++;
            $display("[TB] FAIL pause_at_37: got %h want %h", {bus.data1, bus.data0, bus.running}, {8'h37, 1'b0});
        end
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if ({bus.data1, bus.data0, bus.running} !== {8'h37, 1'b0}) begin
                errors++;
                $display("[TB] FAIL pause_hold cycle %0d: got %h want %h", i, {bus.data1, bus.data0, bus.running}, {8'h37, 1'b0});
                break;
            end
        end
        bus.btn_run = 1'b1;
        n = 0;
        while (bus.running !== 1'b1 && n < 20) begin step(); n++; end
        bus.btn_run = 1'b0;
        m = 0;
        while ({bus.data1, bus.data0} !== 8'h38 && m < 20) begin step(); m++; end
        checks++;
        if (m != 4) begin
            errors++;
            $display("[TB] FAIL resume_tick: got %0d cycles want 4", m);
        end
    endtask

    task automatic test_collision();
        int n;
        n = 0;
        while ({bus.data1, bus.data0} !== 8'h41 && n < 60) begin step(); n++; end
        bus.btn_run = 1'b1;
        bus.btn_clr = 1'b1;
        repeat (5) step();
        checks++;
        if (dut_v !== {8'h42, 2'b10}) begin
            errors++;
            $display("[TB] FAIL pre_collision: got %h want %h", dut_v, {8'h42, 2'b10});
        end
        step();
        checks++;
        if (dut_v !== 10'h000) begin
            errors++;
            $display("[TB] FAIL clr_run_collision: got %h want 000", dut_v);
        end
        bus.btn_run = 1'b0;
        bus.btn_clr = 1'b0;
        repeat (8) step();
        for (int k = 0; k < 2; k++) begin
            bus.btn_run = 1'b1;
            repeat (6) step();
            bus.btn_run = 1'b0;
            n = 0;
            while ({bus.data1, bus.data0} !== 8'h05 && n < 60) begin step(); n++; end
            repeat (2) step();
            if (k == 0) bus.btn_clr = 1'b1;
            else        bus.btn_run = 1'b1;
            repeat (5) step();
            checks++;
            if (dut_v !== {8'h06, 2'b10}) begin
                errors++;
                $display("[TB] FAIL pre_tick_collision k=%0d: got %h want %h", k, dut_v, {8'h06, 2'b10});
            end
            step();
            checks++;
            if (dut_v !== ((k == 0) ? 10'h000 : {8'h07, 2'b00})) begin
                errors++;
                $display("[TB] FAIL tick_collision k=%0d: got %h want %h", k, dut_v, (k == 0) ? 10'h000 : {8'h07, 2'b00});
            end
            bus.btn_run = 1'b0;
            bus.btn_clr = 1'b0;
            repeat (10) step();
        end
        checks++;
        if (dut_v !== {8'h07, 2'b00}) begin
            errors++;
            $display("[TB] FAIL stop_hold_07: got %h want %h", dut_v, {8'h07, 2'b00});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.btn_run = 1'b1;
        repeat (6) step();
        bus.btn_run = 1'b0;
        n = 0;
        while ({bus.data1, bus.data0} !== 8'h98 && n < 500) begin step(); n++; end
        checks++;
        if ({bus.data1, bus.data0} !== 8'h98) begin
            errors++;
            $display("[TB] FAIL reach_98: got %h want 98", {bus.data1, bus.data0});
        end
        repeat (2) step();
        FPGA_RST = 1'b1;
        step();
        FPGA_RST = 1'b0;
        checks++;
        if (dut_v !== 10'h000) begin
            errors++;
            $display("[TB] FAIL reset_mid_count: got %h want 000", dut_v);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (dut_v !== 10'h000) begin
                errors++;
                $display("[TB] FAIL after_reset_quiet cycle %0d: got %h want 000", i, dut_v);
                break;
            end
        end
    endtask

    task automatic test_random();
        int sel, len, gap;
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 8);
            gap = $urandom_range(0, 30);
            bus.btn_run = (sel <= 5) || (sel == 8);
            bus.btn_clr = (sel == 6) || (sel == 7) || (sel == 8);
            FPGA_RST    = (sel == 9);
            for (int i = 0; i < len + gap; i++) begin
                step();
                FPGA_RST = 1'b0;
                if (i == len - 1) begin
                    bus.btn_run = 1'b0;
                    bus.btn_clr = 1'b0;
                end
                checks++;
                if (dut_v !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL random_vs_model k=%0d i=%0d: got %h want %h", k, i, dut_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_digit_range();
        checks++;
        if (range_viol !== 0) begin
            errors++;
            $display("[TB] FAIL digit_range: got %0d cycles with a digit above 9, want 0", range_viol);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_debounce();
        test_carry();
        test_pause();
        test_collision();
        test_reset_mid();
        test_random();
        test_digit_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_counter_2digit.md
BCD_COUNTER_2DIGIT -- requirements
Module: bcd_counter_2digit

Interface
REQ-001 Parameter DIV, default 5_000_000: FPGA_CLK cycles per count tick (10 Hz at 50 MHz); legal range 2..2^26.
REQ-002 Parameter DEB_CYCLES, default 1_000_000: cycles a synchronised button level must stay stable before it is accepted (20 ms at 50 MHz); legal range 2..2^24.
REQ-003 FPGA_CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 FPGA_RST  input  1  reset, synchronous, active-high.
REQ-005 btn_run  input  1  raw start/stop push-button, active-high, asynchronous to FPGA_CLK.
REQ-006 btn_clr  input  1  raw clear push-button, active-high, asynchronous to FPGA_CLK.
REQ-007 data0  output  4  units digit, BCD 0..9, registered; feeds the display multiplexer's data0.
REQ-008 data1  output  4  tens digit, BCD 0..9, registered; feeds the display multiplexer's data1.
REQ-009 running  output  1  high while the FSM is in RUN, registered.
REQ-010 wrap  output  1  one-cycle pulse when the count wraps 99 -> 00, registered.

Function
REQ-011 Each button SHALL pass a 2-flop synchroniser, then a debouncer; the accepted level SHALL update only after DEB_CYCLES consecutive identical synchronised samples.
REQ-012 A press event SHALL be a single-cycle pulse on the accepted level's 0->1 transition; release SHALL generate no event.
REQ-013 The FSM SHALL have two states: STOP and RUN; a run event SHALL toggle STOP<->RUN on the next clock edge.
REQ-014 A clr event SHALL force the state to STOP and both digits to 0 on the next edge, regardless of state.
REQ-015 A clr event and a run event in the same cycle SHALL resolve as clear only (STOP, 00).
REQ-016 The prescaler SHALL be held at 0 in STOP and count 0..DIV-1 in RUN; a tick SHALL occur in the cycle it equals DIV-1, after which it returns to 0.
REQ-017 Because of REQ-016, the first increment SHALL occur exactly DIV cycles after the edge that enters RUN; pausing SHALL discard the partial prescaler count.
REQ-018 On a tick: data0 increments; if data0 was 9, it becomes 0 and data1 increments; if data1 was also 9, both become 0 and wrap pulses high for exactly that one cycle.
REQ-019 Digits SHALL never hold values 10..15; the increment logic SHALL be per-digit BCD, not binary add plus conversion.
REQ-020 In STOP, data0/data1 SHALL hold their value indefinitely.
REQ-021 A tick coinciding with a clr event SHALL be discarded (result 00, wrap stays 0).
REQ-022 A tick coinciding with a run event (RUN->STOP) SHALL still be applied; the state becomes STOP on the same edge.

Reset
REQ-023 While FPGA_RST is high at a clock edge: state=STOP, data0=0, data1=0, running=0, wrap=0, prescaler=0, synchroniser flops=0, debounce counters=0, accepted levels=0.
REQ-024 A button held high through reset SHALL NOT produce a press event until the debouncer has accepted a low level and then a new high level.
REQ-025 Reset asserted mid-count SHALL take effect on the next edge with no partial tick or wrap pulse.

Structure
REQ-026 The state encoding (STOP=0, RUN=1) and the default values of DIV and DEB_CYCLES SHALL live in the shared display package/include file, next to the display-mux constants.
REQ-027 The synchroniser, debouncer and edge detector SHALL be one sub-module, btn_debounce (parameter DEB_CYCLES; ports FPGA_CLK, FPGA_RST, btn_raw, level, press), instantiated twice.
REQ-028 Counter widths SHALL be derived from the parameters with $clog2, with no hard-coded widths.

Verification (DIV=4, DEB_CYCLES=3)
REQ-029 Reset with btn_run held high, then release reset -> no press event, running=0, 00 held for 50 cycles.
REQ-030 Press btn_run for 2 cycles -> rejected by the debouncer; press for 6 cycles -> running=1 exactly 3+2+1 cycles after the rising input edge; first data0=1 exactly 4 cycles after running rises.
REQ-031 Run to 09 -> next tick gives 10; run to 99 -> next tick gives 00 with wrap=1 for exactly one cycle.
REQ-032 Start at 37, press btn_run -> running=0 and 37 held for 100 cycles; press again -> 38 appears exactly 4 cycles after re-entry to RUN.
REQ-033 Force clr and run events in the same cycle while at 42 in RUN -> next edge gives STOP, 00, wrap=0.
REQ-034 Assert FPGA_RST for one cycle at 98 mid-prescaler -> 00 and STOP on the next edge, no wrap pulse; bench checks that digits never exceed 9 throughout.
